// File: rtl/mult_pkg.sv
// Shared types and helpers for the shift-and-add multiplier sequencer.
// Contents: seq_state_t sequencer state encoding, cnt_width() iteration counter width.
// No ports; imported by mult_bit_counter and mult_sequencer.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } seq_state_t;

  // Width of the iteration counter: it only has to hold n-1 down to 0.
  function automatic int cnt_width(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/mult_bit_counter.sv
// Loadable down-counter tracking the remaining add/shift iterations.
// Latency: load/decrement take effect on the next rising edge.
// Ports: clock, n_reset (async active-low), load (cnt <= n-1), dec (count down),
//        cnt (current value), last (cnt == 0).
module mult_bit_counter
  import mult_pkg::*;
#(
  parameter int n = 8
) (
  input  logic                   clock,
  input  logic                   n_reset,
  input  logic                   load,
  input  logic                   dec,
  output logic [cnt_width(n)-1:0] cnt,
  output logic                   last
);

  localparam int CW = cnt_width(n);
  localparam logic [CW-1:0] LOAD_VAL = CW'(n - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Saturates at zero so an extra decrement never wraps back to n-1.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = LOAD_VAL;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign last = (cnt_q == '0);

endmodule

// File: rtl/mult_sequencer.sv
// Control unit for the n-bit shift-and-add multiplier (adder + AQ register).
// Ports: clock, n_reset (async active-low), start (level request), Q0 (AQ LSB) in;
//        reset (clear A, load Q), shift, add_shift, ready, and subtract when the
//        SIGNED_EN macro is defined (two's-complement / Robertson final step).
// Flow: IDLE/DONE --start--> INIT (1 cycle) -> RUN (n cycles) -> DONE (ready held).
module mult_sequencer
  import mult_pkg::*;
#(
  parameter int n = 8
) (
  input  logic clock,
  input  logic n_reset,
  input  logic start,
  input  logic Q0,
  output logic reset,
  output logic shift,
  output logic add_shift,
  output logic ready
`ifdef SIGNED_EN
  ,
  output logic subtract
`endif
);

  localparam int CW = cnt_width(n);

  seq_state_t    state_q;
  seq_state_t    state_d;
  logic          reset_q;
  logic          reset_d;
  logic          ready_q;
  logic          ready_d;
  logic          run_q;
  logic          run_d;
  logic [CW-1:0] cnt;
  logic          last;

  mult_bit_counter #(
    .n (n)
  ) u_cnt (
    .clock   (clock),
    .n_reset (n_reset),
    .load    (state_q == INIT),
    .dec     (state_q == RUN),
    .cnt     (cnt),
    .last    (last)
  );

  // start is only looked at from IDLE and DONE; mid-multiply requests are dropped.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = INIT;
      INIT: state_d = RUN;
      RUN:  if (cnt == '0) state_d = DONE;
      DONE: if (start) state_d = INIT;
      default: state_d = IDLE;
    endcase
  end

  // Strobes decoded from the next state so they are flop outputs and drop to
  // zero the instant n_reset asserts.
  always_comb begin
    reset_d = (state_d == INIT);
    ready_d = (state_d == DONE);
    run_d   = (state_d == RUN);
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= IDLE;
      reset_q <= 1'b0;
      ready_q <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      reset_q <= reset_d;
      ready_q <= ready_d;
      run_q   <= run_d;
    end
  end

  assign reset = reset_q;
  assign ready = ready_q;

  // Q0 steers each step combinationally; the datapath samples it the same cycle.
  assign add_shift = run_q & Q0;
  assign shift     = run_q & ~Q0;

`ifdef SIGNED_EN
  // Robertson: the multiplier sign bit has negative weight, so the last step
  // subtracts M instead of adding it.
  assign subtract = run_q & Q0 & last;
`endif

endmodule

// File: tb/tb_mult_sequencer.sv
// Self-checking bench for mult_sequencer (n=8) driving a small AQ datapath model.
// Expected results come from plain arithmetic on the operands and cycle counts.
// Build with SIGNED_EN defined to exercise the two's-complement variant.
module tb_mult_sequencer;

  localparam int N = 8;

  logic clock = 1'b0;
  logic n_reset = 1'b0;
  logic start = 1'b0;
  logic q0;
  logic reset_o, shift_o, add_shift_o, ready_o;
`ifdef SIGNED_EN
  logic subtract_o;
`endif

  logic [7:0] dp_m = '0;
  logic [7:0] dp_a = '0;
  logic [7:0] dp_q = '0;
  logic       dp_c = 1'b0;
  logic [7:0] q_load = '0;
  logic [8:0] dp_sum;

  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  mult_sequencer #(
    .n (N)
  ) dut (
    .clock     (clock),
    .n_reset   (n_reset),
    .start     (start),
    .Q0        (q0),
    .reset     (reset_o),
    .shift     (shift_o),
    .add_shift (add_shift_o),
    .ready     (ready_o)
`ifdef SIGNED_EN
    ,
    .subtract  (subtract_o)
`endif
  );

  // Datapath: C,A,Q register with adder, controlled only by the DUT strobes.
  assign q0 = dp_q[0];
`ifdef SIGNED_EN
  assign dp_sum = subtract_o ? ({dp_a[7], dp_a} - {dp_m[7], dp_m})
                             : ({dp_a[7], dp_a} + {dp_m[7], dp_m});
`else
  assign dp_sum = {1'b0, dp_a} + {1'b0, dp_m};
`endif

  always @(posedge clock) begin
    if (reset_o) begin
      dp_c <= 1'b0;
      dp_a <= '0;
      dp_q <= q_load;
    end else if (add_shift_o) begin
`ifdef SIGNED_EN
      dp_a <= dp_sum[8:1];
      dp_q <= {dp_sum[0], dp_q[7:1]};
`else
      {dp_c, dp_a, dp_q} <= {dp_sum, dp_q} >> 1;
`endif
    end else if (shift_o) begin
`ifdef SIGNED_EN
      dp_a <= {dp_a[7], dp_a[7:1]};
      dp_q <= {dp_a[0], dp_q[7:1]};
`else
      {dp_c, dp_a, dp_q} <= {dp_c, dp_a, dp_q} >> 1;
`endif
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] expected_product(input logic [7:0] m, input logic [7:0] q);
    logic signed [15:0] sm, sq;
`ifdef SIGNED_EN
    sm = $signed(m);
    sq = $signed(q);
    return 16'(sm * sq);
`else
    return 16'(m) * 16'(q);
`endif
  endfunction

  function automatic logic [3:0] all_outputs();
`ifdef SIGNED_EN
    return {reset_o, shift_o, add_shift_o | subtract_o, ready_o};
`else
    return {reset_o, shift_o, add_shift_o, ready_o};
`endif
  endfunction

  // One multiply: start pulsed (or toggled randomly through the run); j counts
  // negedge samples after the start edge E0 (j=0 INIT, j=1..8 RUN, j=9 DONE).
  task automatic run_mult(input logic [7:0] m, input logic [7:0] q, input bit toggle);
    int first_ready = -1;
    int adds = 0;
    int shifts = 0;
    int subs = 0;
    @(negedge clock);
    dp_m = m;
    q_load = q;
    start = 1'b1;
    @(posedge clock);
    for (int j = 0; j < 20 && first_ready < 0; j++) begin
      @(negedge clock);
      check("excl", 32'(shift_o & add_shift_o), 32'd0);
      check("reset_only_init", 32'(reset_o), 32'(j == 0));
      if (j == 0) check("no_strobe_init", 32'(shift_o | add_shift_o), 32'd0);
      if (j >= 1 && j <= N) begin
        adds += int'(add_shift_o);
        shifts += int'(shift_o);
        // Step k examines multiplier bit k-1 of the original Q.
        check("step_op", 32'(add_shift_o), 32'(q[j-1]));
`ifdef SIGNED_EN
        subs += int'(subtract_o);
        check("sub_pos", 32'(subtract_o), 32'((j == N) && q[N-1]));
`endif
      end
      if (ready_o) first_ready = j;
      start = (toggle && j < N + 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    start = 1'b0;
    check("latency", 32'(first_ready), 32'(N + 1));
    check("add_count", 32'(adds), 32'($countones(q)));
    check("shift_count", 32'(shifts), 32'(N - $countones(q)));
`ifdef SIGNED_EN
    check("sub_count", 32'(subs), 32'(q[N-1]));
`endif
    check("product", 32'({dp_a, dp_q}), 32'(expected_product(m, q)));
    repeat (3) @(negedge clock);
    check("done_hold", 32'(all_outputs()), 32'b0001);
  endtask

  // start held high in DONE: INIT every n+2 cycles, ready low n+1 cycles between.
  task automatic run_b2b(input logic [7:0] m, input logic [7:0] q);
    int last_init = -1;
    int fall = -1;
    int inits = 0;
    logic prev_ready = 1'b1;
    @(negedge clock);
    dp_m = m;
    q_load = q;
    start = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (reset_o) begin
        inits++;
        if (last_init >= 0) check("b2b_period", 32'(c - last_init), 32'(N + 2));
        last_init = c;
      end
      if (ready_o && !prev_ready) begin
        check("b2b_gap", 32'(c - fall), 32'(N + 1));
        check("b2b_product", 32'({dp_a, dp_q}), 32'(expected_product(m, q)));
      end
      if (!ready_o && prev_ready) fall = c;
      prev_ready = ready_o;
    end
    start = 1'b0;
    check("b2b_inits", 32'(inits), 32'd4);
    for (int c = 0; c < 20 && !ready_o; c++) @(negedge clock);
    check("b2b_settle", 32'(ready_o), 32'd1);
  endtask

  // Async reset in the middle of RUN: outputs clear at once, nothing is flagged ready.
  task automatic reset_mid_run();
    @(negedge clock);
    dp_m = 8'h5A;
    q_load = 8'hFF;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (4) @(negedge clock);
    check("pre_abort_run", 32'(add_shift_o), 32'd1);
    @(posedge clock);
    #2 n_reset = 1'b0;
    #1 check("abort_same_cycle", 32'(all_outputs()), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      check("abort_held", 32'(all_outputs()), 32'd0);
    end
    n_reset = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clock);
      check("abort_idle", 32'(all_outputs()), 32'd0);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_reset = 1'b0;
    start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      check("reset_state", 32'(all_outputs()), 32'd0);
    end
    n_reset = 1'b1;
    @(negedge clock);
    check("idle_state", 32'(all_outputs()), 32'd0);

    run_mult(8'd13, 8'd11, 1'b0);
    run_mult(8'd77, 8'd0, 1'b0);
    run_mult(8'hFF, 8'hFF, 1'b0);
`ifdef SIGNED_EN
    run_mult(8'hFD, 8'hFB, 1'b0);
    run_mult(8'd7, 8'hFE, 1'b0);
`else
    run_mult(8'hFD, 8'hFB, 1'b0);
`endif
    for (int i = 0; i < 6; i++) begin
      run_mult(8'($urandom), 8'($urandom), 1'(i % 2));
    end
    run_b2b(8'd13, 8'd11);
    reset_mid_run();
    run_mult(8'd13, 8'd11, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
